// File: rtl/key_evt_fifo.sv
// Key event FIFO between the keypad debouncer and an async CPU read port.
// Ports: clk, reset (async, active-low), key_code/key_valid in,
//   ncs/noe async CPU strobes, rd_data/irq/overflow/count out.
module key_evt_fifo #(
    parameter int B     = 3,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [B:0]               key_code,
    input  logic                     key_valid,
    input  logic                     ncs,
    input  logic                     noe,
    output logic [B:0]               rd_data,
    output logic                     irq,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Strobes are synchronized inverted so a cleared flop means idle.
    logic          cs_meta, cs_sync;
    logic          oe_meta, oe_sync;
    logic          rd_active, rd_active_q;
    // Chain-filled tracker plus arm flag: a strobe already
    // asserted when reset releases must not produce a pop.
    logic [1:0]    sync_ok;
    logic          armed;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [B:0]    mem [DEPTH];

    logic          full;
    logic          pop_req;
    logic          do_pop;
    logic          do_push;
    logic [CW-1:0] count_next;

    assign rd_active = cs_sync & oe_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_meta     <= 1'b0;
            cs_sync     <= 1'b0;
            oe_meta     <= 1'b0;
            oe_sync     <= 1'b0;
            rd_active_q <= 1'b0;
            sync_ok     <= 2'b00;
            armed       <= 1'b0;
        end else begin
            cs_meta     <= ~ncs;
            cs_sync     <= cs_meta;
            oe_meta     <= ~noe;
            oe_sync     <= oe_meta;
            rd_active_q <= rd_active;
            sync_ok     <= {sync_ok[0], 1'b1};
            if (sync_ok[1] && !rd_active && !rd_active_q)
                armed <= 1'b1;
        end
    end

    always_comb begin
        full       = (count == CW'(DEPTH));
        pop_req    = rd_active_q & ~rd_active & armed;
        do_pop     = pop_req && (count != '0);
        do_push    = key_valid && (!full || do_pop);
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            irq      <= 1'b0;
            overflow <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            irq   <= (count_next != '0);
            if (key_valid && full && !do_pop)
                overflow <= 1'b1;
            else if (do_pop)
                overflow <= 1'b0;
            // Frozen during a CPU read so the bus sees stable data.
            if (!rd_active && !rd_active_q)
                rd_data <= (count != '0) ? mem[rd_ptr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= key_code;
    end

endmodule

// File: tb/tb_key_evt_fifo.sv
// Self-checking bench for key_evt_fifo with a queue scoreboard.
// Ports driven: clk, reset, key_code, key_valid, ncs, noe.
module tb_key_evt_fifo;

    localparam int B     = 3;
    localparam int DEPTH = 8;

    logic         clk       = 1'b0;
    logic         reset     = 1'b0;
    logic [B:0]   key_code  = '0;
    logic         key_valid = 1'b0;
    logic         ncs       = 1'b1;
    logic         noe       = 1'b1;
    logic [B:0]   rd_data;
    logic         irq;
    logic         overflow;
    logic [3:0]   count;

    int checks = 0;
    int errors = 0;

    logic [B:0] exp_q[$];
    logic       exp_ovf = 1'b0;

    key_evt_fifo #(.B(B), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_code  (key_code),
        .key_valid (key_valid),
        .ncs       (ncs),
        .noe       (noe),
        .rd_data   (rd_data),
        .irq       (irq),
        .overflow  (overflow),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [B:0] exp_head();
        return (exp_q.size() > 0) ? exp_q[0] : '0;
    endfunction

    task automatic do_push(input logic [B:0] code);
        key_code  = code;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back(code);
        else exp_ovf = 1'b1;
        checks++;
        if (count !== 4'(exp_q.size())) begin
            errors++;
            $display("FAIL push_count got %0d want %0d",
                     count, exp_q.size());
        end
        checks++;
        if (irq !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL push_irq got %0b want %0b",
                     irq, exp_q.size() != 0);
        end
        checks++;
        if (overflow !== exp_ovf) begin
            errors++;
            $display("FAIL push_ovf got %0b want %0b",
                     overflow, exp_ovf);
        end
    endtask

    // CPU read strobe of len clocks; optional key pulse on the pop edge.
    task automatic run_read(input int len, input bit push_at_pop,
                            input logic [B:0] code);
        logic [B:0] want;
        want = exp_head();
        ncs = 1'b0;
        noe = 1'b0;
        for (int i = 0; i < len; i++) begin
            tick();
            checks++;
            if (rd_data !== want) begin
                errors++;
                $display("FAIL strobe_data got %0d want %0d",
                         rd_data, want);
            end
        end
        ncs = 1'b1;
        noe = 1'b1;
        tick();
        tick();
        if (push_at_pop) begin
            key_code  = code;
            key_valid = 1'b1;
        end
        tick();
        key_valid = 1'b0;
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            exp_ovf = 1'b0;
        end
        if (push_at_pop) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(code);
            else exp_ovf = 1'b1;
        end
        tick();
        checks++;
        if (count !== 4'(exp_q.size())) begin
            errors++;
            $display("FAIL read_count got %0d want %0d",
                     count, exp_q.size());
        end
        checks++;
        if (irq !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL read_irq got %0b want %0b",
                     irq, exp_q.size() != 0);
        end
        checks++;
        if (overflow !== exp_ovf) begin
            errors++;
            $display("FAIL read_ovf got %0b want %0b",
                     overflow, exp_ovf);
        end
        checks++;
        if (rd_data !== exp_head()) begin
            errors++;
            $display("FAIL read_data got %0d want %0d",
                     rd_data, exp_head());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({count, irq, overflow, rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_outs got c=%0d i=%0b o=%0b d=%0d want 0",
                     count, irq, overflow, rd_data);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (count !== 4'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got c=%0d i=%0b want 0",
                     count, irq);
        end
    endtask

    task automatic test_single_push();
        do_push(4'd5);
        checks++;
        if (rd_data !== 4'd0) begin
            errors++;
            $display("FAIL single_lat0 got %0d want 0", rd_data);
        end
        tick();
        checks++;
        if (rd_data !== 4'd5) begin
            errors++;
            $display("FAIL single_lat1 got %0d want 5", rd_data);
        end
        run_read(3, 1'b0, '0);
    endtask

    task automatic test_order();
        do_push(4'd3);
        do_push(4'd7);
        run_read(6, 1'b0, '0);
        run_read(3, 1'b0, '0);
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= DEPTH + 1; k++) do_push(4'(k));
        run_read(3, 1'b0, '0);
        checks++;
        if (rd_data !== 4'd2) begin
            errors++;
            $display("FAIL ovf_next got %0d want 2", rd_data);
        end
    endtask

    task automatic test_full_coincident();
        do_push(4'd10);
        run_read(3, 1'b1, 4'd11);
        while (exp_q.size() > 0) run_read(2, 1'b0, '0);
    endtask

    task automatic test_empty_read();
        run_read(5, 1'b0, '0);
    endtask

    task automatic test_reset_mid_strobe();
        do_push(4'd2);
        do_push(4'd4);
        ncs = 1'b0;
        noe = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        exp_q.delete();
        exp_ovf = 1'b0;
        checks++;
        if ({count, irq, overflow, rd_data} !== '0) begin
            errors++;
            $display("FAIL midrst_outs got c=%0d i=%0b o=%0b d=%0d want 0",
                     count, irq, overflow, rd_data);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        do_push(4'd6);
        for (int i = 0; i < 3; i++) tick();
        ncs = 1'b1;
        noe = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (count !== 4'd1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL midrst_nopop got c=%0d i=%0b want 1/1",
                     count, irq);
        end
        checks++;
        if (rd_data !== 4'd6) begin
            errors++;
            $display("FAIL midrst_data got %0d want 6", rd_data);
        end
        run_read(3, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        logic [B:0] c;
        for (int i = 0; i < 5; i++) begin
            c = 4'($urandom_range(1, 15));
            do_push(c);
        end
        while (exp_q.size() > 0) run_read(1, 1'b0, '0);
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_order();
        test_overflow();
        test_full_coincident();
        test_empty_read();
        test_reset_mid_strobe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
